delay_arbiter: RTL
==================

# delay_arbiter

Round-robin arbiter and sequencer for one shared down-counter used as a programmable delay timer. Up to NREQ requesters each present a delay length. The block grants the counter to one requester at a time, loads it, counts down to zero, and returns a one-cycle `done` pulse to the grantee. It sits between simulation/test agents or FSMs that need "wait N cycles" service and the single counter resource, replacing per-agent counters.

## Interface
- `NREQ`, default 3: number of requesters (≥2).
- `W`, default 8: counter and delay width in bits.

- `c`  in  1: clock. All state updates on posedge `c`.
- `rst`  in  1: synchronous reset, active-high.
- `req`  in  NREQ: request per requester. Must be held until `done` is seen.
- `delay`  in  NREQ*W: requester i's delay is `delay[i*W +: W]`. Sampled only at grant.
- `grant`  out  NREQ: one-hot current owner, or 0 when idle.
- `done`  out  NREQ: one-cycle pulse to the owner at the end of its delay.
- `busy`  out  1: counter in use (state ≠ IDLE).
- `count`  out  W: current counter value.

## Operation
- States: IDLE, RUN, DONE.
- Round-robin pointer `ptr`, range 0..NREQ-1, holds the last granted index. The search order is ptr+1, ptr+2, … modulo NREQ.
- IDLE, some `req` set at the edge:
  - winner g gets `grant[g]`=1 and `count`=delay_g.
  - Next state is RUN if delay_g>0, otherwise DONE.
- IDLE, no `req`: outputs hold at 0.
- RUN, `req[g]`=1 at the edge:
  - `count` decrements.
  - When `count`==1, `count` becomes 0 and the next state is DONE.
- RUN, `req[g]`=0 at the edge (abort):
  - Next state IDLE; `grant`=0, `count`=0, `ptr`=g.
  - No `done` is produced.
- DONE:
  - `done[g]`=1 for exactly this state.
  - `req` is ignored.
  - Next edge: state IDLE, `grant`=0, `done`=0, `ptr`=g.
- Arithmetic: `count` is unsigned W-bit. It never underflows; a decrement happens only when `count`≥1. Maximum delay is 2^W−1.
- `busy` = (state ≠ IDLE). `done` and `grant` are registered outputs.

## Timing
- Reset values: state IDLE, `grant`=0, `done`=0, `busy`=0, `count`=0, `ptr`=NREQ-1 (so index 0 wins first).
- Let edge k be the grant edge (IDLE sees `req`):
  - `grant` is high after edge k.
  - `done[g]` is high in the cycle after edge k+N, for every N including N=0.
  - `grant` and `busy` drop after edge k+N+1.
- The earliest next grant is edge k+N+2, since one IDLE cycle is mandatory between owners.
- Simultaneous requests: the winner is the first set bit in round-robin order. Losers wait with no timeout.
- Reset has priority over all events. `rst` mid-RUN or mid-DONE drops every output to the reset value on that edge, with no `done` pulse, and resets `ptr`.
- A `req` set and cleared while not granted is never latched.

## Structure
- Shared package/header `delay_arbiter_pkg`:
  - state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - default NREQ and W constants.
- Sub-module `rr_pick`, combinational:
  - inputs `req` and `ptr`;
  - outputs one-hot `gnt`, index `idx`, and `any`.
- The top level holds the FSM, pointer, counter, and output registers.

## Test plan
1. Reset, then `req`=001 with delay0=5 held → `grant`=001 after edge k. `count` runs 5,4,3,2,1,0. `done`=001 for one cycle after edge k+5. `busy`=0 after edge k+6.
2. `req`=111 with all delays 2, held, re-asserted after each `done` → grant order 001, 010, 100, 001. Each owner gets `done` 2 cycles after its grant, with exactly one IDLE cycle between owners.
3. `req`=010 with delay1=0 → `grant`=010 and `done`=010 in the same cycle after the grant edge. Back to IDLE on the next edge; `count` stays 0.
4. Abort: req1 granted with delay 6; `req[1]` dropped when `count`=3 → next edge IDLE, `grant`=0, no `done[1]`. With `req`=101 pending, the next grant is 100.
5. `rst` asserted for one edge during RUN with `count`=4 → all outputs 0 after that edge. With `req`=101, the next grant is 001.
6. delay0=255 (W=8) → `done` after edge k+255. `count` never wraps past 0; `busy` is continuous for 256 cycles.

Source files
------------

// File: rtl/delay_arbiter_pkg.sv
// Shared constants for the delay arbiter: state encoding, default sizes
// and a helper that sizes the round-robin pointer.
package delay_arbiter_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int DEF_NREQ = 3;
  localparam int DEF_W    = 8;

  // Index width needed to name one of n requesters (at least one bit).
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/delay_arbiter_rr_pick.sv
// Combinational round-robin picker: starting just after ptr, finds the
// first set request bit and reports it as one-hot, as an index, and as
// an any-request flag.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);

  // Walk the requesters in order ptr+1, ptr+2, ... wrapping at NREQ; the first hit wins.
  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      j = int'(ptr) + off;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/delay_arbiter.sv
// Round-robin arbiter in front of one shared down-counter. A granted
// requester has its delay loaded, the counter runs to zero, and the owner
// gets a one-cycle done pulse. One idle cycle always separates owners.
module delay_arbiter
  import delay_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W
) (
  input  logic            c,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] delay,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] done,
  output logic            busy,
  output logic [W-1:0]    count
);

  localparam int PW = ptr_width(NREQ);

  logic [1:0]      state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [NREQ-1:0] pickGnt;
  logic [PW-1:0]   pickIdx;
  logic            pickAny;
  logic [W-1:0]    pickDelay;

  rr_pick #(
    .NREQ(NREQ),
    .PW  (PW)
  ) u_pick (
    .req(req),
    .ptr(ptr),
    .gnt(pickGnt),
    .idx(pickIdx),
    .any(pickAny)
  );

  // Select the delay field belonging to whichever requester the picker chose.
  always_comb begin
    pickDelay = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pickGnt[i]) pickDelay = delay[i*W +: W];
    end
  end

  assign busy = (state != IDLE);

  // Sequencer: grant in IDLE, count down in RUN (abort if the owner lets go), pulse done in DONE.
  always_ff @(posedge c) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      done  <= '0;
      count <= '0;
      ptr   <= PW'(NREQ - 1);
      owner <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= '0;
          if (pickAny) begin
            grant <= pickGnt;
            owner <= pickIdx;
            count <= pickDelay;
            if (pickDelay == '0) begin
              state <= DONE;
              done  <= pickGnt;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (req[owner]) begin
            if (count <= W'(1)) begin
              count <= '0;
              state <= DONE;
              done  <= grant;
            end else begin
              count <= count - W'(1);
            end
          end else begin
            state <= IDLE;
            grant <= '0;
            count <= '0;
            ptr   <= owner;
          end
        end
        DONE: begin
          state <= IDLE;
          grant <= '0;
          done  <= '0;
          count <= '0;
          ptr   <= owner;
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          done  <= '0;
          count <= '0;
        end
      endcase
    end
  end

endmodule
